// File: rtl/icache_invalidator_if.sv
// ---------------------------------------------------------------------------
// icache_invalidator_if
//
// Bundle between the invalidation sequencer, its requester (fetch/cache
// controller) and the wide invalidate port of the I-cache valid-bit RAM.
//
// Request handshake: a request (fence_req or line_req) is accepted on a
// rising clock edge where the request is high and req_ready is high. The
// requester holds its request until it sees req_ready; requests seen while
// req_ready is low are ignored, not queued.
//
// Signals:
//   fence_req   requester -> sequencer  full-cache sweep request
//   line_req    requester -> sequencer  single-entry invalidation request
//   line_addr   requester -> sequencer  entry index for line_req
//   req_ready   sequencer -> requester  high only while idle
//   busy        sequencer -> requester  high while a sequence runs
//   done        sequencer -> requester  one-cycle completion pulse
//   ien         sequencer -> RAM        invalidate-port enable
//   invalidate  sequencer -> RAM        invalidate-port write enable
//   iaddr       sequencer -> RAM        row index
//   idata       sequencer -> RAM        row write data
//   dummy_data  RAM -> sequencer        registered row read-back
//
// Modports: slave is the sequencer's view, master is the environment's view
// (requester plus valid RAM).
// ---------------------------------------------------------------------------
interface icache_invalidator_if #(
  parameter int ADDR_WIDTH            = 6,
  parameter int INVALIDATE_WIDTH_BITS = 6,
  parameter int INVALIDATE_ADDR_WIDTH = 1
);
  logic                                fence_req;
  logic                                line_req;
  logic [ADDR_WIDTH-1:0]               line_addr;
  logic                                req_ready;
  logic                                busy;
  logic                                done;
  logic                                ien;
  logic                                invalidate;
  logic [INVALIDATE_ADDR_WIDTH-1:0]    iaddr;
  logic [2**INVALIDATE_WIDTH_BITS-1:0] idata;
  logic [2**INVALIDATE_WIDTH_BITS-1:0] dummy_data;

  modport slave (
    input  fence_req, line_req, line_addr, dummy_data,
    output req_ready, busy, done, ien, invalidate, iaddr, idata
  );

  modport master (
    output fence_req, line_req, line_addr, dummy_data,
    input  req_ready, busy, done, ien, invalidate, iaddr, idata
  );
endinterface

// File: rtl/icache_invalidator.sv
// ---------------------------------------------------------------------------
// icache_invalidator
//
// Invalidation sequencer for the I-cache valid-bit RAM. Runs full sweeps
// (fence.i) that zero every invalidate-port row, and single-entry
// invalidations done as a read-modify-write of one row.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   bus          icache_invalidator_if.slave (request handshake + RAM port)
//   o_dbg_state  current FSM state (IDLE=0, SWEEP=1, LREAD=2, LWRITE=3,
//                DONE=4)
//
// Optional feature macro: ICACHE_INVALIDATOR_RESET_SWEEP_EN
//   defined   -> reset enters SWEEP at row 0, so leaving reset clears the
//                whole valid RAM (which has no reset of its own)
//   undefined -> reset enters IDLE
// ---------------------------------------------------------------------------
module icache_invalidator #(
  parameter int DATA_WIDTH_BITS       = 1,
  parameter int ADDR_WIDTH            = 6,
  parameter int INVALIDATE_WIDTH_BITS = 6,
  parameter int INVALIDATE_ADDR_WIDTH = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  icache_invalidator_if.slave   bus,
  output logic [2:0]            o_dbg_state
);

  localparam int ROW_W  = 2**INVALIDATE_WIDTH_BITS;
  localparam int ENT_W  = 2**DATA_WIDTH_BITS;
  localparam int SLOT_W = ADDR_WIDTH - INVALIDATE_ADDR_WIDTH;
  localparam logic [INVALIDATE_ADDR_WIDTH-1:0] LAST_ROW = {INVALIDATE_ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SWEEP  = 3'd1,
    S_LREAD  = 3'd2,
    S_LWRITE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                           r_state;
  logic [INVALIDATE_ADDR_WIDTH-1:0] r_counter;
  logic [INVALIDATE_ADDR_WIDTH-1:0] r_iaddr;
  logic [ROW_W-1:0]                 r_mask;   // ones over the slot being cleared
  logic                             r_merge;  // high exactly in LWRITE
  logic                             r_ien;
  logic                             r_inv;
  logic                             r_done;
  logic                             r_busy;
  logic                             r_ready;

  logic [SLOT_W-1:0]                w_slot;
  logic [INVALIDATE_ADDR_WIDTH-1:0] w_row;
  logic [ROW_W-1:0]                 w_slot_mask;

  assign w_row       = bus.line_addr[ADDR_WIDTH-1 -: INVALIDATE_ADDR_WIDTH];
  assign w_slot      = bus.line_addr[SLOT_W-1:0];
  assign w_slot_mask = ROW_W'({ENT_W{1'b1}}) << (w_slot * ENT_W);

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef ICACHE_INVALIDATOR_RESET_SWEEP_EN
      r_state <= S_SWEEP;
      r_ien   <= 1'b1;
      r_inv   <= 1'b1;
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
`else
      r_state <= S_IDLE;
      r_ien   <= 1'b0;
      r_inv   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
`endif
      r_counter <= '0;
      r_iaddr   <= '0;
      r_mask    <= '0;
      r_merge   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // fence wins a tie; the sweep also covers any concurrent line request
          if (bus.fence_req) begin
            r_state   <= S_SWEEP;
            r_counter <= '0;
            r_iaddr   <= '0;
            r_ien     <= 1'b1;
            r_inv     <= 1'b1;
            r_busy    <= 1'b1;
            r_ready   <= 1'b0;
          end else if (bus.line_req) begin
            r_state <= S_LREAD;
            r_iaddr <= w_row;
            r_mask  <= w_slot_mask;
            r_ien   <= 1'b1;
            r_inv   <= 1'b0;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (r_counter == LAST_ROW) begin
            r_state <= S_DONE;
            r_ien   <= 1'b0;
            r_inv   <= 1'b0;
            r_iaddr <= '0;
            r_done  <= 1'b1;
          end else begin
            r_counter <= r_counter + 1'b1;
            r_iaddr   <= r_counter + 1'b1;
          end
        end
        S_LREAD: begin
          r_state <= S_LWRITE;
          r_inv   <= 1'b1;
          r_merge <= 1'b1;
        end
        S_LWRITE: begin
          r_state <= S_DONE;
          r_ien   <= 1'b0;
          r_inv   <= 1'b0;
          r_iaddr <= '0;
          r_merge <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ien   <= 1'b0;
          r_inv   <= 1'b0;
          r_iaddr <= '0;
          r_merge <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // The RAM read-back only becomes valid in the LWRITE cycle, so the merge
  // is gated straight from the RAM's output register; every other port
  // output comes from a flop in this module.
  assign bus.idata      = r_merge ? (bus.dummy_data & ~r_mask) : '0;
  assign bus.ien        = r_ien;
  assign bus.invalidate = r_inv;
  assign bus.iaddr      = r_iaddr;
  assign bus.done       = r_done;
  assign bus.busy       = r_busy;
  assign bus.req_ready  = r_ready;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_icache_invalidator.sv
// ---------------------------------------------------------------------------
// tb_icache_invalidator
//
// Drives random fence/line requests (held until accepted) into
// icache_invalidator, models the valid RAM behind the invalidate port, and
// compares every cycle's port outputs with a trace built from the
// transaction-level behaviour of each accepted request. Ends with a
// directed reset-abort sequence and a RAM content check.
// ---------------------------------------------------------------------------
module tb_icache_invalidator;

  localparam int DWB    = 1;
  localparam int AW     = 6;
  localparam int IWB    = 6;
  localparam int IAW    = 1;
  localparam int RW     = 2**IWB;
  localparam int ROWS   = 2**IAW;
  localparam int D      = 2**DWB;
  localparam int SLOT_W = AW - IAW;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  icache_invalidator_if #(
    .ADDR_WIDTH(AW), .INVALIDATE_WIDTH_BITS(IWB), .INVALIDATE_ADDR_WIDTH(IAW)
  ) bus ();

  icache_invalidator #(
    .DATA_WIDTH_BITS(DWB), .ADDR_WIDTH(AW),
    .INVALIDATE_WIDTH_BITS(IWB), .INVALIDATE_ADDR_WIDTH(IAW)
  ) dut (
    .clock      (clk),
    .reset      (rst),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  // Valid RAM behind the invalidate port: registered read-back.
  logic [RW-1:0] ram [ROWS];
  always @(posedge clk) begin
    if (bus.ien) begin
      bus.dummy_data <= ram[bus.iaddr];
      if (bus.invalidate) ram[bus.iaddr] <= bus.idata;
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic           ien;
    logic           inv;
    logic [IAW-1:0] iaddr;
    logic [RW-1:0]  idata;
    logic           done;
    logic           busy;
    logic           ready;
  } cyc_t;

  cyc_t          exp_q[$];
  logic [RW-1:0] model_ram [ROWS];
  int            vectors     = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cyc_t idle_cyc();
    cyc_t c;
    c       = '0;
    c.ready = 1'b1;
    return c;
  endfunction

  function automatic cyc_t sweep_cyc(input int row);
    cyc_t c;
    c       = '0;
    c.ien   = 1'b1;
    c.inv   = 1'b1;
    c.iaddr = row[IAW-1:0];
    c.busy  = 1'b1;
    return c;
  endfunction

  function automatic cyc_t done_cyc();
    cyc_t c;
    c      = '0;
    c.done = 1'b1;
    c.busy = 1'b1;
    return c;
  endfunction

  // A sweep writes zero to every row from 'first' upward, then pulses done.
  task automatic push_sweep(input int first);
    for (int r = first; r < ROWS; r++) exp_q.push_back(sweep_cyc(r));
    exp_q.push_back(done_cyc());
    for (int r = 0; r < ROWS; r++) model_ram[r] = '0;
  endtask

  // A line request reads its row, writes it back with its slot cleared.
  task automatic push_line(input logic [AW-1:0] addr);
    int            row;
    int            k;
    logic [RW-1:0] nd;
    cyc_t          c;
    row = int'(addr) / (2**SLOT_W);
    k   = int'(addr) % (2**SLOT_W);
    nd  = model_ram[row];
    for (int b = 0; b < D; b++) nd[k*D + b] = 1'b0;
    c = '0; c.ien = 1'b1; c.iaddr = row[IAW-1:0]; c.busy = 1'b1;
    exp_q.push_back(c);
    c.inv = 1'b1; c.idata = nd;
    exp_q.push_back(c);
    exp_q.push_back(done_cyc());
    model_ram[row] = nd;
  endtask

  task automatic check_outputs(input string tag, input cyc_t e);
    chk({tag, ".ien"},        RW'(bus.ien),        RW'(e.ien));
    chk({tag, ".invalidate"}, RW'(bus.invalidate), RW'(e.inv));
    chk({tag, ".iaddr"},      RW'(bus.iaddr),      RW'(e.iaddr));
    chk({tag, ".idata"},      bus.idata,           e.idata);
    chk({tag, ".done"},       RW'(bus.done),       RW'(e.done));
    chk({tag, ".busy"},       RW'(bus.busy),       RW'(e.busy));
    chk({tag, ".req_ready"},  RW'(bus.req_ready),  RW'(e.ready));
  endtask

  // Called at each negedge: compares against the next expected cycle.
  task automatic check_cycle(input string tag);
    cyc_t e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : idle_cyc();
    check_outputs(tag, e);
  endtask

  task automatic drive_req(input logic f, input logic l, input logic [AW-1:0] a);
    bus.fence_req = f;
    bus.line_req  = l;
    bus.line_addr = a;
  endtask

  // ---------------- stimulus ----------------
  logic          pend_f;
  logic          pend_l;
  logic [AW-1:0] pend_a;
  int            n_ops;
  bit            idle_now;

  initial begin
    rst = 1'b1;
    drive_req(1'b0, 1'b0, '0);
    for (int r = 0; r < ROWS; r++) ram[r] = {$urandom, $urandom};
    ram[0] = '1;
    for (int r = 0; r < ROWS; r++) model_ram[r] = ram[r];

    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef ICACHE_INVALIDATOR_RESET_SWEEP_EN
    check_outputs("reset", sweep_cyc(0));
    rst = 1'b0;
    push_sweep(1);
`else
    check_outputs("reset", idle_cyc());
    rst = 1'b0;
`endif

    // Random phase: requester holds each request until it is accepted.
    pend_f = 1'b0; pend_l = 1'b0; pend_a = '0; n_ops = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      idle_now = (exp_q.size() == 0);
      check_cycle("run");
      if (!pend_f && !pend_l) begin
        case (n_ops)
          0: begin pend_l = 1'b1; pend_a = AW'(5); end
          1: begin pend_f = 1'b1; pend_l = 1'b1; pend_a = AW'($urandom_range(0, 2**AW-1)); end
          default: if ($urandom_range(0, 2) != 0) begin
            pend_f = ($urandom_range(0, 3) == 0);
            pend_l = !pend_f || ($urandom_range(0, 1) == 1);
            pend_a = AW'($urandom_range(0, 2**AW-1));
          end
        endcase
      end
      drive_req(pend_f, pend_l, pend_a);
      if (idle_now && (pend_f || pend_l)) begin
        if (pend_f) push_sweep(0);
        else        push_line(pend_a);
        pend_f = 1'b0;
        pend_l = 1'b0;
        n_ops++;
      end
    end

    // Drain any sequence still in flight.
    drive_req(1'b0, 1'b0, '0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_cycle("drain");
    end

    // Reset during the first sweep cycle aborts the sweep.
    ram[0] = '1;
    ram[1] = {$urandom, $urandom} | 64'h1;
    model_ram[0] = ram[0];
    model_ram[1] = ram[1];
    drive_req(1'b1, 1'b0, '0);
    @(negedge clk);
    check_outputs("abort.sweep0", sweep_cyc(0));
    drive_req(1'b0, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    model_ram[0] = '0;
`ifdef ICACHE_INVALIDATOR_RESET_SWEEP_EN
    check_outputs("abort.reset", sweep_cyc(0));
    rst = 1'b0;
    push_sweep(1);
`else
    check_outputs("abort.reset", idle_cyc());
    rst = 1'b0;
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_cycle("abort.after");
    end

    for (int r = 0; r < ROWS; r++) chk($sformatf("ram_row%0d", r), ram[r], model_ram[r]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
